// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundling the decode, redirect, instruction-memory and F/D signals.
interface fetch_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        fd_wen;
  logic [15:0] instr_out;
  logic [15:0] oldPC_out;
  logic [15:0] newPC_out;
  logic        halted;
  modport master (
    input  stall, redirect, redirect_pc, imem_rdy, imem_data,
    output imem_req, imem_addr, fd_wen, instr_out, oldPC_out, newPC_out, halted
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_rdy, imem_data,
    input  imem_req, imem_addr, fd_wen, instr_out, oldPC_out, newPC_out, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with stall hold, redirect drain and optional HLT stop (FETCH_HALT_DETECT_EN).
module fetch_stage (
  input logic      clk,
  input logic      rst,
  fetch_if.master  io_f
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;
  state_t      r_state, w_state_nx;
  logic [15:0] r_pc, r_hold, r_pend;
  logic [15:0] w_pc_nx, w_hold_nx, w_pend_nx, w_pc_inc;
  logic        w_hlt;
  assign w_pc_inc       = r_pc + 16'd2;
  assign io_f.imem_req  = !rst && (r_state == FETCH || r_state == DRAIN);
  assign io_f.imem_addr = r_pc;
  assign io_f.fd_wen    = !rst && !io_f.redirect && !io_f.stall &&
                          ((r_state == FETCH && io_f.imem_rdy) || r_state == HOLD);
  assign io_f.instr_out = rst ? 16'h0000 : (r_state == HOLD ? r_hold : io_f.imem_data);
  assign io_f.oldPC_out = rst ? 16'h0000 : r_pc;
  assign io_f.newPC_out = io_f.oldPC_out + 16'd2;
`ifdef FETCH_HALT_DETECT_EN
  assign w_hlt       = io_f.instr_out[15:12] == 4'hF;
  assign io_f.halted = !rst && r_state == HALT;
`else
  assign w_hlt       = 1'b0;
  assign io_f.halted = 1'b0;
`endif
  // redirect wins over everything; in DRAIN the in-flight word is always discarded
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_hold_nx  = r_hold;
    w_pend_nx  = r_pend;
    case (r_state)
      FETCH:
        if (io_f.redirect) begin
          if (io_f.imem_rdy) w_pc_nx = io_f.redirect_pc;
          else begin
            w_pend_nx  = io_f.redirect_pc;
            w_state_nx = DRAIN;
          end
        end else if (io_f.imem_rdy && io_f.stall) begin
          w_hold_nx  = io_f.imem_data;
          w_state_nx = HOLD;
        end else if (io_f.imem_rdy) begin
          w_pc_nx    = w_pc_inc;
          w_state_nx = w_hlt ? HALT : FETCH;
        end
      HOLD:
        if (io_f.redirect) begin
          w_pc_nx    = io_f.redirect_pc;
          w_state_nx = FETCH;
        end else if (!io_f.stall) begin
          w_pc_nx    = w_pc_inc;
          w_state_nx = w_hlt ? HALT : FETCH;
        end
      DRAIN:
        if (io_f.imem_rdy) begin
          w_pc_nx    = io_f.redirect ? io_f.redirect_pc : r_pend;
          w_state_nx = FETCH;
        end else if (io_f.redirect) w_pend_nx = io_f.redirect_pc;
      default:
        if (io_f.redirect) begin
          w_pc_nx    = io_f.redirect_pc;
          w_state_nx = FETCH;
        end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= 16'h0000;
      r_hold  <= 16'h0000;
      r_pend  <= 16'h0000;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_hold  <= w_hold_nx;
      r_pend  <= w_pend_nx;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a queued F/D scoreboard and per-cycle output probes.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_if bus ();
  fetch_stage dut (.clk(clk), .rst(rst), .io_f(bus));
  always #5 clk = ~clk;
  logic [47:0] q_fd[$];
  int n_chk = 0;
  int n_pass = 0;
  logic p_on = 1'b0, p_addr_on = 1'b0, p_rst = 1'b0, done = 1'b0;
  logic p_req = 1'b0, p_halt = 1'b0;
  logic [15:0] p_addr = 16'h0000;
  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  // monitor: every falling edge compare whatever the stimulus announced for this cycle
  always @(negedge clk) begin
    if (bus.fd_wen === 1'b1) begin
      if (q_fd.size() == 0) chk("unexpected_fd_wen", {32'h0, bus.instr_out}, 48'h0);
      else chk("fd_word", {bus.instr_out, bus.oldPC_out, bus.newPC_out}, q_fd.pop_front());
    end
    if (p_on) begin
      chk("imem_req", {47'h0, bus.imem_req}, {47'h0, p_req});
      chk("halted", {47'h0, bus.halted}, {47'h0, p_halt});
      if (p_addr_on) chk("imem_addr", {32'h0, bus.imem_addr}, {32'h0, p_addr});
    end
    if (p_rst) begin
      chk("rst_fd_wen", {47'h0, bus.fd_wen}, 48'h0);
      chk("rst_instr", {32'h0, bus.instr_out}, 48'h0);
      chk("rst_oldpc", {32'h0, bus.oldPC_out}, 48'h0);
      chk("rst_newpc", {32'h0, bus.newPC_out}, 48'h2);
    end
    if (done) begin
      chk("queue_empty", {16'h0, 32'(q_fd.size())}, 48'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end
  task automatic drv(input logic s, input logic r, input logic [15:0] rpc,
                     input logic rdy, input logic [15:0] d);
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = rpc;
    bus.imem_rdy = rdy;
    bus.imem_data = d;
  endtask
  task automatic probe(input logic req, input logic a_on, input logic [15:0] a, input logic h);
    p_on = 1'b1;
    p_req = req;
    p_addr_on = a_on;
    p_addr = a;
    p_halt = h;
  endtask
  task automatic push(input logic [15:0] i, input logic [15:0] o, input logic [15:0] n);
    q_fd.push_back({i, o, n});
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    p_on = 1'b0;
    p_rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    drv(0, 0, 16'h0, 1, 16'h1234);
    cyc();
    p_rst = 1'b1; probe(0, 0, 16'h0, 0);
    cyc();
    // zero-wait back-to-back delivery; first request at 0x0000 right out of reset
    rst = 1'b0;
    drv(0, 0, 16'h0, 1, 16'h1111); push(16'h1111, 16'h0000, 16'h0002); probe(1, 1, 16'h0000, 0);
    cyc();
    drv(0, 0, 16'h0, 1, 16'h2222); push(16'h2222, 16'h0002, 16'h0004); probe(1, 1, 16'h0002, 0);
    cyc();
    // stall for three cycles with the word parked in HOLD
    rst = 1'b1; drv(0, 0, 16'h0, 0, 16'h0);
    cyc();
    rst = 1'b0;
    drv(1, 0, 16'h0, 1, 16'hABCD); probe(1, 1, 16'h0000, 0);
    cyc();
    drv(1, 0, 16'h0, 0, 16'h0); probe(0, 1, 16'h0000, 0);
    cyc();
    drv(1, 0, 16'h0, 0, 16'h0); probe(0, 1, 16'h0000, 0);
    cyc();
    drv(0, 0, 16'h0, 0, 16'h0); push(16'hABCD, 16'h0000, 16'h0002); probe(0, 0, 16'h0, 0);
    cyc();
    drv(0, 0, 16'h0, 1, 16'h3333); push(16'h3333, 16'h0002, 16'h0004); probe(1, 1, 16'h0002, 0);
    cyc();
    // redirect while 0x0004 is outstanding; its word returns two cycles later and is dropped
    drv(0, 1, 16'h0040, 0, 16'h0); probe(1, 1, 16'h0004, 0);
    cyc();
    drv(0, 0, 16'h0, 0, 16'h0); probe(1, 1, 16'h0004, 0);
    cyc();
    drv(0, 0, 16'h0, 1, 16'hDEAD); probe(1, 1, 16'h0004, 0);
    cyc();
    drv(0, 0, 16'h0, 0, 16'h0); probe(1, 1, 16'h0040, 0);
    cyc();
    // redirect beats a ready, unstalled word
    drv(0, 1, 16'hFFFE, 1, 16'h6666); probe(1, 1, 16'h0040, 0);
    cyc();
    drv(0, 0, 16'h0, 1, 16'h5555); push(16'h5555, 16'hFFFE, 16'h0000); probe(1, 1, 16'hFFFE, 0);
    cyc();
    drv(1, 0, 16'h0, 1, 16'h7777); probe(1, 1, 16'h0000, 0);
    cyc();
    drv(1, 1, 16'h0100, 0, 16'h0); probe(0, 1, 16'h0000, 0);
    cyc();
    drv(0, 1, 16'h0010, 1, 16'h8888); probe(1, 1, 16'h0100, 0);
    cyc();
    drv(0, 0, 16'h0, 1, 16'hF000); push(16'hF000, 16'h0010, 16'h0012); probe(1, 1, 16'h0010, 0);
    cyc();
`ifdef FETCH_HALT_DETECT_EN
    drv(1, 0, 16'h0, 1, 16'h1234); probe(0, 0, 16'h0, 1);
    cyc();
    drv(0, 1, 16'h0020, 0, 16'h0); probe(0, 0, 16'h0, 1);
    cyc();
    drv(0, 0, 16'h0, 0, 16'h0); probe(1, 1, 16'h0020, 0);
    cyc();
`else
    drv(0, 0, 16'h0, 0, 16'h0); probe(1, 1, 16'h0012, 0);
    cyc();
`endif
    // reset lands in DRAIN together with a late memory response
    drv(0, 1, 16'h0200, 0, 16'h0); probe(1, 0, 16'h0, 0);
    cyc();
    rst = 1'b1;
    drv(0, 0, 16'h0, 1, 16'h9999); p_rst = 1'b1; probe(0, 0, 16'h0, 0);
    cyc();
    rst = 1'b0;
    drv(0, 0, 16'h0, 0, 16'h0); probe(1, 1, 16'h0000, 0);
    cyc();
    drv(0, 0, 16'h0, 1, 16'h4242); push(16'h4242, 16'h0000, 16'h0002); probe(1, 1, 16'h0000, 0);
    cyc();
    drv(0, 0, 16'h0, 0, 16'h0); probe(1, 1, 16'h0002, 0);
    cyc();
    done = 1'b1;
    cyc();
  end
endmodule
